// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Video timing bus from the VGA timing generator to the
//               renderer and game logic (syncs, blanking, pixel position,
//               line/frame strobes).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;

  // Timing generator side
  modport master (
    output hsync, vsync, blank_n, x, y, line_start, frame_start
  );

  // Consumer side (renderer, game logic)
  modport slave (
    input  hsync, vsync, blank_n, x, y, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 VGA timing generator running in the 50 MHz board
//               clock domain; advances one pixel per rising edge of the
//               25 MHz vga_clk, which is sampled as data.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic         vga_clk,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);

  // Both counters are 10 bits wide, so neither total may exceed 1024.
  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic       vga_clk_d_q;
  logic [9:0] h_count_q,     h_count_d;
  logic [9:0] v_count_q,     v_count_d;
  logic       hsync_q,       hsync_d;
  logic       vsync_q,       vsync_d;
  logic       blank_n_q,     blank_n_d;
  logic [9:0] x_q,           x_d;
  logic [9:0] y_q,           y_d;
  logic       line_start_q,  line_start_d;
  logic       frame_start_q, frame_start_d;

  logic        pix_tick;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [31:0] h_wide;
  logic [31:0] v_wide;
  logic        active;

  // Next counter values and their decode; registers load only on a pixel tick.
  always_comb begin
    pix_tick = vga_clk & ~vga_clk_d_q;

    h_next = (h_count_q == H_LAST) ? 10'd0 : h_count_q + 10'd1;
    if (h_count_q == H_LAST) begin
      v_next = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end else begin
      v_next = v_count_q;
    end

    // Widened copies keep comparisons correct when a boundary equals 1024.
    h_wide = 32'(h_next);
    v_wide = 32'(v_next);
    active = (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);

    // Levels hold between ticks; strobes are one clk wide.
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_tick) begin
      h_count_d     = h_next;
      v_count_d     = v_next;
      hsync_d       = ((h_wide >= H_SYNC_START) && (h_wide < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_wide >= V_SYNC_START) && (v_wide < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      blank_n_d     = active;
      x_d           = active ? h_next : 10'd0;
      y_d           = active ? v_next : 10'd0;
      line_start_d  = (h_next == 10'd0);
      frame_start_d = (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

  // State and output registers; reset parks the counters one pixel before (0,0).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_clk_d_q   <= 1'b0;
      h_count_q     <= H_LAST;
      v_count_q     <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_n_q     <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vga_clk_d_q   <= vga_clk;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Consumes the 25 MHz VGA_CLK square wave produced by the board clock divider and generates 640x480@60 Hz VGA timing. Outputs are hsync, vsync, blank_n, the current pixel coordinates and frame/line start strobes. The whole block runs in the 50 MHz board clock domain. It advances one pixel per rising edge of VGA_CLK. The renderer uses x/y to draw the player and blocks. Game logic can use frame_start as a once-per-frame update strobe.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  50 MHz board clock; all logic is on its rising edge
resetn  input  1  synchronous active-low reset
vga_clk  input  1  25 MHz pixel clock from the divider, sampled as data in the clk domain
hsync  output  1  horizontal sync, level set by SYNC_POL
vsync  output  1  vertical sync, level set by SYNC_POL
blank_n  output  1  1 = active video region
x  output  10  pixel column in the active region, else 0
y  output  10  pixel row in the active region, else 0
line_start  output  1  one-clk pulse when h_count wraps to 0
frame_start  output  1  one-clk pulse when (h_count, v_count) wraps to (0,0)

Behaviour:
- Pixel tick:
  - vga_clk_d is vga_clk registered on clk.
  - pix_tick = vga_clk & ~vga_clk_d (rising edge of vga_clk).
  - Nothing advances on clk cycles without pix_tick. All outputs hold, except the strobes, which drop to 0.
- Totals and counter widths:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - h_count and v_count are 10 bits each. Both totals must be at most 1024; this is a parameter legality rule.
- Counter update on pix_tick:
  - h_count = (h_count == H_TOTAL-1) ? 0 : h_count+1.
  - When h_count wraps: v_count = (v_count == V_TOTAL-1) ? 0 : v_count+1.
- Reset (resetn=0 at a clk edge; identical behaviour mid-frame):
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1, vga_clk_d=0.
  - hsync=vsync=~SYNC_POL (deasserted), blank_n=0, x=0, y=0, line_start=0, frame_start=0.
  - Effect: the first pix_tick after reset wraps to (0,0) and pulses frame_start and line_start.
- Output register timing:
  - All outputs are registered and are loaded on the same clk edge that updates the counters.
  - They are decoded from the new counter values, so counters and outputs are always mutually consistent. Latency is zero pixels.
- Decode from the new counter values (h, v):
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line including porches; else ~SYNC_POL.
  - blank_n = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x = blank_n ? h : 0; y = blank_n ? v : 0.
  - line_start = 1 when h == 0; frame_start = 1 when h == 0 && v == 0.
- Strobes are exactly one clk wide: cleared on every clk edge without pix_tick.
- vga_clk stuck high or low: no pix_tick, so counters and levels freeze; strobes stay 0.
- Resetn low coinciding with pix_tick: reset wins.

Test Plan:
1. Reset: hold resetn=0 for 3 clk with vga_clk toggling -> hsync=1, vsync=1, blank_n=0, x=y=0, both strobes 0.
2. Release reset, vga_clk toggling every clk (period 2 clk) -> first pix_tick gives frame_start=line_start=1 for 1 clk, blank_n=1, x=0, y=0. On the next pix_tick x=1 and both strobes are 0.
3. Horizontal line -> blank_n falls when x reaches 640. hsync is low for exactly 96 pix_ticks, starting at h=656. Wrap 799->0 gives a line_start pulse and y increments by 1.
4. Full frame -> vsync is low for exactly 2*800 pix_ticks starting at line 490. frame_start pulses are 420000 pix_ticks (840000 clk) apart. blank_n is high for 640*480 = 307200 pix_ticks per frame.
5. Freeze: hold vga_clk=1 for 50 clk at h=100 -> x stays 100 and strobes stay 0. On resume x=101 at the first rising edge.
6. Mid-frame reset: assert resetn=0 at (h=300, v=200) -> next clk returns to the reset values. The first pix_tick after release pulses frame_start with x=0, y=0.
